// File: rtl/cic_comb_mc.sv
// Multichannel CIC comb (differentiator) section: up to 16 unit-delay comb stages per channel, then shift + saturate.
// Latency: fixed CIC_MAX_NUMSECS+1 cycles from Data_In_Valid to Data_Out_Valid, whatever numsecs is configured.
// Backpressure: none; one sample per cycle is always accepted in RUN, samples outside RUN are dropped.
//
// Ports:
//   CLK, nRST                         clock and asynchronous active-low reset
//   isConfig / isConfigDone           config request / one-cycle pulse once the new config is active
//   Data_Config_In                    [3:0] numsecs-1, [9:4] right shift, upper bits ignored
//   Data_In, Data_In_Valid, _ChIdx    decimated integrator sample, strobe and channel tag
//   Data_Out, Data_Out_Valid, _ChIdx  scaled, saturated sample, strobe and channel tag (held while not valid)
module cic_comb_mc #(
    parameter int MIDDLE_WIDTH          = 37,
    parameter int OUTPUT_WIDTH          = 16,
    parameter int CIC_MAX_NUMSECS       = 16,
    parameter int CIC_MAX_CHANNELS      = 16,
    parameter int CIC_CONFIG_DATA_WIDTH = 16
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             isConfig,
    output logic                             isConfigDone,
    input  logic [CIC_CONFIG_DATA_WIDTH-1:0] Data_Config_In,
    input  logic [MIDDLE_WIDTH-1:0]          Data_In,
    input  logic                             Data_In_Valid,
    input  logic [3:0]                       Data_In_ChIdx,
    output logic [OUTPUT_WIDTH-1:0]          Data_Out,
    output logic                             Data_Out_Valid,
    output logic [3:0]                       Data_Out_ChIdx
);

    localparam int MW = MIDDLE_WIDTH;
    localparam int OW = OUTPUT_WIDTH;
    localparam int NS = CIC_MAX_NUMSECS;
    localparam int NC = CIC_MAX_CHANNELS;

    localparam logic [5:0] SHIFT_MAX = 6'(MW - 1);

    // Saturation limits expressed at comb width; the low OW bits are the output codes.
    localparam logic signed [MW-1:0] SAT_MAX = MW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [MW-1:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // Config FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   accept;     // sample enters the comb chain this cycle
    logic   flush;      // drop all in-flight valids and zero every delay slot
    logic   cfg_load;   // latch Data_Config_In

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  if (isConfig) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_DONE;
            ST_DONE: state_d = ST_RUN;
            ST_RUN:  if (isConfig) state_d = ST_LOAD;
            default: state_d = ST_RST;
        endcase
    end

    // Flushing already on the isConfig beat keeps anything accepted earlier
    // from reaching the output while LOAD/DONE are in progress.
    always_comb begin
        isConfigDone = (state_q == ST_DONE);
        cfg_load     = (state_q == ST_LOAD);
        accept       = (state_q == ST_RUN) && !isConfig && Data_In_Valid;
        flush        = (state_q == ST_LOAD) || ((state_q == ST_RUN) && isConfig);
    end

    // ------------------------------------------------------------------
    // Config registers (reset word 0x0003: 4 stages, shift 0)
    // ------------------------------------------------------------------
    logic [3:0] numsecs_m1_q;
    logic [5:0] shift_q, shift_d;
    logic [5:0] cfg_shift;
    logic       unused_cfg_bits;

    assign cfg_shift       = Data_Config_In[9:4];
    assign unused_cfg_bits = ^Data_Config_In[CIC_CONFIG_DATA_WIDTH-1:10];

    // Shifting by the full comb width or more has no meaning; clamp to a pure sign result.
    assign shift_d = (int'(cfg_shift) >= MW) ? SHIFT_MAX : cfg_shift;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            numsecs_m1_q <= 4'd3;
            shift_q      <= 6'd0;
        end else if (cfg_load) begin
            numsecs_m1_q <= Data_Config_In[3:0];
            shift_q      <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Comb chain: one registered stage per physical section
    // ------------------------------------------------------------------
    // Each stage reads and writes its own delay slot on the beat it handles,
    // so the same channel on consecutive cycles always sees the freshest
    // delay value without any forwarding.
    for (genvar k = 0; k < NS; k++) begin : g_stage
        localparam logic [3:0] KIDX = 4'(k);

        logic          vld_in;
        logic [3:0]    ch_in;
        logic [MW-1:0] dat_in;
        logic [MW-1:0] dly_rd;
        logic          act;
        logic [MW-1:0] dat_d;

        logic          vld_q;
        logic [3:0]    ch_q;
        logic [MW-1:0] dat_q;
        logic [MW-1:0] dly_q [NC];

        if (k == 0) begin : g_head
            assign vld_in = accept;
            assign ch_in  = Data_In_ChIdx;
            assign dat_in = Data_In;
        end else begin : g_body
            assign vld_in = g_stage[k-1].vld_q;
            assign ch_in  = g_stage[k-1].ch_q;
            assign dat_in = g_stage[k-1].dat_q;
        end

        assign dly_rd = dly_q[ch_in];
        assign act    = (KIDX <= numsecs_m1_q);
        // Modulo-2^MW difference: wrap is what makes the CIC integrator/comb pair exact.
        assign dat_d  = act ? (dat_in - dly_rd) : dat_in;

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                vld_q <= 1'b0;
                ch_q  <= 4'd0;
                dat_q <= '0;
                for (int c = 0; c < NC; c++) begin
                    dly_q[c] <= '0;
                end
            end else if (flush) begin
                vld_q <= 1'b0;
                for (int c = 0; c < NC; c++) begin
                    dly_q[c] <= '0;
                end
            end else begin
                vld_q <= vld_in;
                if (vld_in) begin
                    ch_q  <= ch_in;
                    dat_q <= dat_d;
                    if (act) begin
                        dly_q[ch_in] <= dat_in;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: arithmetic shift, saturate, register
    // ------------------------------------------------------------------
    logic                 last_vld;
    logic [3:0]           last_ch;
    logic [MW-1:0]        last_dat;
    logic signed [MW-1:0] shifted;
    logic [OW-1:0]        out_dat_d;

    logic                 out_vld_q;
    logic [3:0]           out_ch_q;
    logic [OW-1:0]        out_dat_q;

    assign last_vld = g_stage[NS-1].vld_q;
    assign last_ch  = g_stage[NS-1].ch_q;
    assign last_dat = g_stage[NS-1].dat_q;

    assign shifted = $signed(last_dat) >>> shift_q;

    always_comb begin
        out_dat_d = shifted[OW-1:0];
        if (shifted > SAT_MAX) begin
            out_dat_d = SAT_MAX[OW-1:0];
        end else if (shifted < SAT_MIN) begin
            out_dat_d = SAT_MIN[OW-1:0];
        end
    end

    // Data and tag only move on a valid beat, so they hold between samples.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_vld_q <= 1'b0;
            out_ch_q  <= 4'd0;
            out_dat_q <= '0;
        end else if (flush) begin
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= last_vld;
            if (last_vld) begin
                out_ch_q  <= last_ch;
                out_dat_q <= out_dat_d;
            end
        end
    end

    assign Data_Out       = out_dat_q;
    assign Data_Out_Valid = out_vld_q;
    assign Data_Out_ChIdx = out_ch_q;

endmodule
